fill_rect_cmd_encoder: RTL and testbench

Serializes one parallel fill-rectangle command into the 11-byte stream consumed by the fill-rect decode engine, and pushes it into the command FIFO over the rts/rtr byte handshake. It sits between the host-side command source (register bank / command generator) and the command FIFO write port. A one-deep pending slot lets the source queue the next command while the current one is streaming. Zero-area commands are dropped, not sent.

---
 rtl/fill_rect_cmd_encoder_pkg.sv | 55 +++++
 rtl/fill_rect_cmd_encoder.sv | 129 ++++++++++++
 tb/tb_fill_rect_cmd_encoder.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fill_rect_cmd_encoder_pkg.sv
// Shared definitions for the fill-rect command stream: byte numbering (also used
// by the decode engine for its decode states), command record and byte selection.
package fill_rect_cmd_encoder_pkg;

    localparam int CMD_LEN = 11;

    localparam logic [3:0] ORIGX_B1  = 4'd0;
    localparam logic [3:0] ORIGX_B0  = 4'd1;
    localparam logic [3:0] ORIGY_B1  = 4'd2;
    localparam logic [3:0] ORIGY_B0  = 4'd3;
    localparam logic [3:0] WID_B1    = 4'd4;
    localparam logic [3:0] WID_B0    = 4'd5;
    localparam logic [3:0] HGT_B1    = 4'd6;
    localparam logic [3:0] HGT_B0    = 4'd7;
    localparam logic [3:0] RVAL_B    = 4'd8;
    localparam logic [3:0] GVAL_B    = 4'd9;
    localparam logic [3:0] BVAL_B    = 4'd10;
    localparam logic [3:0] LAST_BYTE = 4'(CMD_LEN - 1);

    typedef struct packed {
        logic [15:0] origx;
        logic [15:0] origy;
        logic [15:0] wid;
        logic [15:0] hgt;
        logic [3:0]  rval;
        logic [3:0]  gval;
        logic [3:0]  bval;
    } fill_cmd_t;

    // Byte order is fixed by the decoder: big-endian fields, colour nibbles zero-extended.
    function automatic logic [7:0] cmd_byte(input fill_cmd_t c, input logic [3:0] idx);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            ORIGX_B1: b = c.origx[15:8];
            ORIGX_B0: b = c.origx[7:0];
            ORIGY_B1: b = c.origy[15:8];
            ORIGY_B0: b = c.origy[7:0];
            WID_B1:   b = c.wid[15:8];
            WID_B0:   b = c.wid[7:0];
            HGT_B1:   b = c.hgt[15:8];
            HGT_B0:   b = c.hgt[7:0];
            RVAL_B:   b = {4'h0, c.rval};
            GVAL_B:   b = {4'h0, c.gval};
            BVAL_B:   b = {4'h0, c.bval};
            default:  b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic is_zero_area(input fill_cmd_t c);
        return (c.wid == 16'h0000) || (c.hgt == 16'h0000);
    endfunction

endpackage

// File: rtl/fill_rect_cmd_encoder.sv
// Serializes a parallel fill-rect command into the 11-byte decoder stream and pushes
// it into the command FIFO; one pending slot queues the next command during a stream.
module fill_rect_cmd_encoder
    import fill_rect_cmd_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst_,
    input  logic        cmd_rts,
    output logic        cmd_rtr,
    input  logic [15:0] cmd_origx,
    input  logic [15:0] cmd_origy,
    input  logic [15:0] cmd_wid,
    input  logic [15:0] cmd_hgt,
    input  logic [3:0]  cmd_rval,
    input  logic [3:0]  cmd_gval,
    input  logic [3:0]  cmd_bval,
    input  logic        cmd_fifo_rtr,
    output logic        cmd_fifo_rts,
    output logic [7:0]  cmd_fifo_data,
    output logic        cmd_drop,
    output logic        enc_busy,
    output logic [15:0] cmd_sent_cnt
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } enc_state_t;

    enc_state_t  state_q, state_d;
    logic        pend_vld_q, pend_vld_d;
    logic [3:0]  byte_idx_q, byte_idx_d;
    logic        drop_q, drop_d;
    logic [15:0] sent_cnt_q, sent_cnt_d;
    fill_cmd_t   pend_q, act_q, cmd_in;

    logic accept;
    logic xfc;
    logic last_xfc;
    logic load;

    assign cmd_in = '{origx: cmd_origx, origy: cmd_origy, wid: cmd_wid, hgt: cmd_hgt,
                      rval: cmd_rval, gval: cmd_gval, bval: cmd_bval};

    // The slot is only refilled while empty, so accept and load never share an edge.
    assign cmd_rtr  = !pend_vld_q && rst_;
    assign accept   = cmd_rts && cmd_rtr;
    assign xfc      = (state_q == ST_SEND) && cmd_fifo_rtr;
    assign last_xfc = xfc && (byte_idx_q == LAST_BYTE);
    assign load     = pend_vld_q && ((state_q == ST_IDLE) || last_xfc);

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        state_d    = state_q;
        pend_vld_d = pend_vld_q;
        byte_idx_d = byte_idx_q;
        drop_d     = 1'b0;
        sent_cnt_d = sent_cnt_q;

        if (accept) begin
            pend_vld_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                byte_idx_d = 4'd0;
            end
            ST_SEND: begin
                if (xfc) begin
                    byte_idx_d = byte_idx_q + 4'd1;
                end
                if (last_xfc) begin
                    sent_cnt_d = sent_cnt_q + 16'd1;
                    state_d    = ST_IDLE;
                    byte_idx_d = 4'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Loading from the slot overrides the tail of a finished stream (back-to-back).
        if (load) begin
            pend_vld_d = 1'b0;
            byte_idx_d = 4'd0;
            if (is_zero_area(pend_q)) begin
                drop_d  = 1'b1;
                state_d = ST_IDLE;
            end else begin
                state_d = ST_SEND;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_q    <= ST_IDLE;
            pend_vld_q <= 1'b0;
            byte_idx_q <= 4'd0;
            drop_q     <= 1'b0;
            sent_cnt_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            pend_vld_q <= pend_vld_d;
            byte_idx_q <= byte_idx_d;
            drop_q     <= drop_d;
            sent_cnt_q <= sent_cnt_d;
        end
    end

    // NOTE: command payload registers are not reset; they are only observed behind valid state.
    always_ff @(posedge clk) begin
        if (accept) begin
            pend_q <= cmd_in;
        end
        if (load) begin
            act_q <= pend_q;
        end
    end

    assign cmd_fifo_rts  = (state_q == ST_SEND);
    assign cmd_fifo_data = cmd_fifo_rts ? cmd_byte(act_q, byte_idx_q) : 8'h00;
    assign cmd_drop      = drop_q;
    assign enc_busy      = pend_vld_q || (state_q == ST_SEND);
    assign cmd_sent_cnt  = sent_cnt_q;

endmodule

// File: tb/tb_fill_rect_cmd_encoder.sv
// Directed bench for fill_rect_cmd_encoder: table of commands with expected byte
// streams, plus sequences for backpressure, back-to-back, drop, reset and wrap.
module tb_fill_rect_cmd_encoder;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        cmd_rts = 1'b0;
    logic        cmd_rtr;
    logic [15:0] cmd_origx = '0, cmd_origy = '0, cmd_wid = '0, cmd_hgt = '0;
    logic [3:0]  cmd_rval = '0, cmd_gval = '0, cmd_bval = '0;
    logic        cmd_fifo_rtr = 1'b1;
    logic        cmd_fifo_rts;
    logic [7:0]  cmd_fifo_data;
    logic        cmd_drop;
    logic        enc_busy;
    logic [15:0] cmd_sent_cnt;

    fill_rect_cmd_encoder dut (
        .clk           (clk),
        .rst_          (rst_),
        .cmd_rts       (cmd_rts),
        .cmd_rtr       (cmd_rtr),
        .cmd_origx     (cmd_origx),
        .cmd_origy     (cmd_origy),
        .cmd_wid       (cmd_wid),
        .cmd_hgt       (cmd_hgt),
        .cmd_rval      (cmd_rval),
        .cmd_gval      (cmd_gval),
        .cmd_bval      (cmd_bval),
        .cmd_fifo_rtr  (cmd_fifo_rtr),
        .cmd_fifo_rts  (cmd_fifo_rts),
        .cmd_fifo_data (cmd_fifo_data),
        .cmd_drop      (cmd_drop),
        .enc_busy      (enc_busy),
        .cmd_sent_cnt  (cmd_sent_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ox, oy, w, h;
        logic [3:0]  r, g, b;
        logic [87:0] exp;
    } vec_t;

    vec_t vecs[3];
    vec_t zvecs[2];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_cnt = 0;

    logic [7:0] got_b[$];
    int         got_e[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Log each accepted byte with the edge number at which it transfers.
    always @(negedge clk) begin
        if (rst_ && cmd_fifo_rts && cmd_fifo_rtr) begin
            got_b.push_back(cmd_fifo_data);
            got_e.push_back(cyc + 1);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_cmd(input vec_t v, output int acc);
        bit took;
        took = 1'b0;
        acc = -1;
        cmd_origx = v.ox; cmd_origy = v.oy; cmd_wid = v.w; cmd_hgt = v.h;
        cmd_rval = v.r; cmd_gval = v.g; cmd_bval = v.b;
        cmd_rts = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            took = cmd_rtr;
            @(posedge clk);
            #1;
            if (took) begin
                acc = cyc;
                break;
            end
        end
        cmd_rts = 1'b0;
        if (acc < 0) check("accept_timeout", 32'(took), 32'd1);
    endtask

    task automatic wait_bytes(input int n);
        for (int i = 0; i < 300; i++) begin
            if (got_b.size() >= n) break;
            @(posedge clk);
            #1;
        end
        if (got_b.size() < n) check("byte_wait_timeout", 32'(got_b.size()), 32'(n));
    endtask

    task automatic verify_vec(input vec_t v, input int base, input int first_edge,
                              input bit contiguous, input string tag);
        logic [7:0] b;
        for (int i = 0; i < 11; i++) begin
            b = (got_b.size() > base + i) ? got_b[base + i] : 8'hxx;
            check($sformatf("%s_byte%0d", tag, i), 32'(b), 32'(v.exp[87 - 8 * i -: 8]));
            if (contiguous && got_e.size() > base + i)
                check($sformatf("%s_edge%0d", tag, i), 32'(got_e[base + i]), 32'(first_edge + i));
        end
        if (got_e.size() > base)
            check($sformatf("%s_first_edge", tag), 32'(got_e[base]), 32'(first_edge));
    endtask

    initial begin
        int acc, acc2, acc3, base;

        vecs[0] = '{ox: 16'h0123, oy: 16'h0045, w: 16'h0010, h: 16'h0008,
                    r: 4'hA, g: 4'h5, b: 4'hF, exp: 88'h01230045001000080A050F};
        vecs[1] = '{ox: 16'hFFFF, oy: 16'h8000, w: 16'h0001, h: 16'h0001,
                    r: 4'hF, g: 4'h0, b: 4'h1, exp: 88'hFFFF800000010001_0F0001};
        vecs[2] = '{ox: 16'h00FF, oy: 16'hFF00, w: 16'h1234, h: 16'hABCD,
                    r: 4'h3, g: 4'hC, b: 4'h7, exp: 88'h00FFFF001234ABCD_030C07};
        zvecs[0] = '{ox: 16'h0011, oy: 16'h0022, w: 16'h0000, h: 16'h0005,
                     r: 4'h1, g: 4'h2, b: 4'h3, exp: 88'h0};
        zvecs[1] = '{ox: 16'h0033, oy: 16'h0044, w: 16'h0007, h: 16'h0000,
                     r: 4'h4, g: 4'h5, b: 4'h6, exp: 88'h0};

        // Reset state
        rst_ = 1'b0;
        cmd_fifo_rtr = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rtr", 32'(cmd_rtr), 32'd0);
        check("rst_rts", 32'(cmd_fifo_rts), 32'd0);
        check("rst_data", 32'(cmd_fifo_data), 32'h00);
        check("rst_drop", 32'(cmd_drop), 32'd0);
        check("rst_busy", 32'(enc_busy), 32'd0);
        check("rst_cnt", 32'(cmd_sent_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_ = 1'b1;
        @(negedge clk);
        check("post_rst_rtr", 32'(cmd_rtr), 32'd1);
        @(posedge clk);
        #1;

        // Table of single commands with FIFO always ready
        for (int k = 0; k < 3; k++) begin
            base = got_b.size();
            send_cmd(vecs[k], acc);
            wait_bytes(base + 11);
            repeat (2) @(posedge clk);
            #1;
            check($sformatf("v%0d_count", k), 32'(got_b.size()), 32'(base + 11));
            verify_vec(vecs[k], base, acc + 2, 1'b1, $sformatf("v%0d", k));
            exp_cnt++;
            check($sformatf("v%0d_sent_cnt", k), 32'(cmd_sent_cnt), 32'(exp_cnt));
            check($sformatf("v%0d_idle_busy", k), 32'(enc_busy), 32'd0);
        end

        // Backpressure at byte 4 for 3 cycles
        base = got_b.size();
        send_cmd(vecs[0], acc);
        wait_bytes(base + 4);
        cmd_fifo_rtr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("bp_rts%0d", i), 32'(cmd_fifo_rts), 32'd1);
            check($sformatf("bp_data%0d", i), 32'(cmd_fifo_data), 32'h00);
            @(posedge clk);
            #1;
        end
        cmd_fifo_rtr = 1'b1;
        wait_bytes(base + 11);
        repeat (2) @(posedge clk);
        #1;
        check("bp_count", 32'(got_b.size()), 32'(base + 11));
        verify_vec(vecs[0], base, acc + 2, 1'b0, "bp");
        if (got_e.size() > base + 4)
            check("bp_gap", 32'(got_e[base + 4] - got_e[base + 3]), 32'd4);
        exp_cnt++;
        check("bp_sent_cnt", 32'(cmd_sent_cnt), 32'(exp_cnt));

        // Two commands back-to-back
        base = got_b.size();
        send_cmd(vecs[1], acc2);
        send_cmd(vecs[2], acc3);
        @(negedge clk);
        check("b2b_rtr_full", 32'(cmd_rtr), 32'd0);
        check("b2b_busy", 32'(enc_busy), 32'd1);
        @(posedge clk);
        #1;
        wait_bytes(base + 22);
        repeat (2) @(posedge clk);
        #1;
        check("b2b_count", 32'(got_b.size()), 32'(base + 22));
        verify_vec(vecs[1], base, acc2 + 2, 1'b1, "b2b_a");
        verify_vec(vecs[2], base + 11, acc2 + 2 + 11, 1'b1, "b2b_b");
        exp_cnt += 2;
        check("b2b_sent_cnt", 32'(cmd_sent_cnt), 32'(exp_cnt));

        // Zero-area commands are dropped with a single-cycle pulse
        for (int k = 0; k < 2; k++) begin
            base = got_b.size();
            send_cmd(zvecs[k], acc);
            @(negedge clk);
            check($sformatf("z%0d_drop_early", k), 32'(cmd_drop), 32'd0);
            @(posedge clk);
            #1;
            @(negedge clk);
            check($sformatf("z%0d_drop", k), 32'(cmd_drop), 32'd1);
            check($sformatf("z%0d_rts", k), 32'(cmd_fifo_rts), 32'd0);
            @(posedge clk);
            #1;
            @(negedge clk);
            check($sformatf("z%0d_drop_end", k), 32'(cmd_drop), 32'd0);
            check($sformatf("z%0d_busy", k), 32'(enc_busy), 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("z%0d_no_bytes", k), 32'(got_b.size()), 32'(base));
            check($sformatf("z%0d_sent_cnt", k), 32'(cmd_sent_cnt), 32'(exp_cnt));
        end
        base = got_b.size();
        send_cmd(vecs[1], acc);
        wait_bytes(base + 11);
        repeat (2) @(posedge clk);
        #1;
        verify_vec(vecs[1], base, acc + 2, 1'b1, "after_drop");
        exp_cnt++;
        check("after_drop_sent_cnt", 32'(cmd_sent_cnt), 32'(exp_cnt));

        // Reset in the middle of a stream
        base = got_b.size();
        send_cmd(vecs[0], acc);
        wait_bytes(base + 6);
        rst_ = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_rts", 32'(cmd_fifo_rts), 32'd0);
        check("mid_rst_busy", 32'(enc_busy), 32'd0);
        check("mid_rst_cnt", 32'(cmd_sent_cnt), 32'd0);
        check("mid_rst_rtr", 32'(cmd_rtr), 32'd0);
        @(posedge clk);
        #1;
        rst_ = 1'b1;
        exp_cnt = 0;
        check("mid_rst_partial", 32'(got_b.size()), 32'(base + 6));
        got_b.delete();
        got_e.delete();
        send_cmd(vecs[2], acc);
        wait_bytes(11);
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_count", 32'(got_b.size()), 32'd11);
        verify_vec(vecs[2], 0, acc + 2, 1'b1, "post_rst");
        exp_cnt++;
        check("post_rst_sent_cnt", 32'(cmd_sent_cnt), 32'(exp_cnt));

        // Counter wrap from 0xFFFF
        @(negedge clk);
        force dut.sent_cnt_q = 16'hFFFF;
        #1;
        release dut.sent_cnt_q;
        @(posedge clk);
        #1;
        check("preload_cnt", 32'(cmd_sent_cnt), 32'hFFFF);
        base = got_b.size();
        send_cmd(vecs[0], acc);
        wait_bytes(base + 11);
        repeat (2) @(posedge clk);
        #1;
        verify_vec(vecs[0], base, acc + 2, 1'b1, "wrap");
        check("wrap_cnt", 32'(cmd_sent_cnt), 32'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
